// File: rtl/cache_responder_pkg.sv
// Shared types and constants for the cache responder.
//  cache_rw_e    : processor request kind (read / write / no-op)
//  cache_state_e : responder FSM states
//  CNT_W         : width of the hit/miss statistics counters
//  sat_inc       : saturating increment for the statistics counters
package cache_responder_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    RW_IDLE  = 2'b00,
    RW_WRITE = 2'b01,
    RW_READ  = 2'b10
  } cache_rw_e;

  typedef enum logic [2:0] {
    C_IDLE,
    C_LOOKUP,
    C_WB,
    C_FILL,
    C_RESP
  } cache_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_responder_if.sv
// Bus bundles around the cache responder.
//  cache_responder_if : processor side load/store handshake
//    valid/rw/address_cache/wdata from the processor (master),
//    rdata/rdata_oe/gnt/hit/busy back from the cache (slave).
//  cache_mem_if       : backing-memory req/ack port
//    mem_req/mem_we/mem_addr/mem_wdata from the cache (master),
//    mem_rdata/mem_ack back from memory (slave).
interface cache_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              valid;
  logic [1:0]        rw;
  logic [ADDR_W-1:0] address_cache;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rdata_oe;
  logic              gnt;
  logic              hit;
  logic              busy;

  modport master (
    output valid, rw, address_cache, wdata,
    input  rdata, rdata_oe, gnt, hit, busy
  );

  modport slave (
    input  valid, rw, address_cache, wdata,
    output rdata, rdata_oe, gnt, hit, busy
  );
endinterface

interface cache_mem_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/cache_responder_line_array.sv
// cache_line_array: direct-mapped line storage (tag, valid, dirty, data).
//  clk, rst    : clock, asynchronous active-low reset (clears valid/dirty only)
//  idx         : line index for both the read and the write port
//  we_tag      : write tag_in and set the valid bit
//  we_dirty    : write dirty_in
//  we_data     : write data_in
//  valid/dirty/tag/data : asynchronous read of line idx
module cache_line_array #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 8,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  input  logic               we_tag,
  input  logic [TAG_W-1:0]   tag_in,
  input  logic               we_dirty,
  input  logic               dirty_in,
  input  logic               we_data,
  input  logic [DATA_W-1:0]  data_in,
  output logic               valid,
  output logic               dirty,
  output logic [TAG_W-1:0]   tag,
  output logic [DATA_W-1:0]  data
);
  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]  valid_bits;
  logic [LINES-1:0]  dirty_bits;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  // Valid/dirty need a reset, so they live in per-line flops rather than the RAM arrays.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    logic valid_reg;
    logic dirty_reg;
    logic sel;

    assign sel = (idx == INDEX_W'(gi));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_reg <= 1'b0;
        dirty_reg <= 1'b0;
      end else begin
        if (we_tag && sel)   valid_reg <= 1'b1;
        if (we_dirty && sel) dirty_reg <= dirty_in;
      end
    end

    assign valid_bits[gi] = valid_reg;
    assign dirty_bits[gi] = dirty_reg;
  end

  always_ff @(posedge clk) begin
    if (we_tag)  tag_mem[idx]  <= tag_in;
    if (we_data) data_mem[idx] <= data_in;
  end

  assign valid = valid_bits[idx];
  assign dirty = dirty_bits[idx];
  assign tag   = tag_mem[idx];
  assign data  = data_mem[idx];

endmodule

// File: rtl/cache_responder.sv
// cache_responder: direct-mapped, write-back, write-allocate cache responder.
//  clk       : clock, all state on the rising edge
//  rst       : asynchronous active-low reset; aborts any transaction in flight
//  cpu       : processor handshake (slave side of cache_responder_if)
//  mem       : backing-memory req/ack port (master side of cache_mem_if)
//  hit_cnt   : saturating count of hit responses
//  miss_cnt  : saturating count of miss responses
module cache_responder
  import cache_responder_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  cache_responder_if.slave  cpu,
  cache_mem_if.master       mem,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int TAG_W = ADDR_W - INDEX_W;

  cache_state_e      state_reg, state_next;
  logic [1:0]        rw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              hit_reg;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic               is_read, is_write, is_op;
  logic               lookup_hit;

  logic               line_valid, line_dirty;
  logic [TAG_W-1:0]   line_tag;
  logic [DATA_W-1:0]  line_data;

  logic               we_tag, we_dirty, we_data, dirty_in;
  logic [DATA_W-1:0]  data_in;

  assign idx        = addr_reg[INDEX_W-1:0];
  assign req_tag    = addr_reg[ADDR_W-1:INDEX_W];
  assign is_read    = (rw_reg == RW_READ);
  assign is_write   = (rw_reg == RW_WRITE);
  assign is_op      = is_read || is_write;
  assign lookup_hit = line_valid && (line_tag == req_tag);

  cache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_lines (
    .clk      (clk),
    .rst      (rst),
    .idx      (idx),
    .we_tag   (we_tag),
    .tag_in   (req_tag),
    .we_dirty (we_dirty),
    .dirty_in (dirty_in),
    .we_data  (we_data),
    .data_in  (data_in),
    .valid    (line_valid),
    .dirty    (line_dirty),
    .tag      (line_tag),
    .data     (line_data)
  );

  // Outputs are decoded from the current state so that an async reset
  // drops mem_req/gnt immediately.
  always_comb begin
    state_next    = state_reg;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    cpu.gnt       = 1'b0;
    cpu.hit       = 1'b0;
    cpu.rdata     = '0;
    cpu.rdata_oe  = 1'b0;
    cpu.busy      = (state_reg != C_IDLE);
    we_tag        = 1'b0;
    we_dirty      = 1'b0;
    we_data       = 1'b0;
    dirty_in      = 1'b0;
    data_in       = wdata_reg;

    unique case (state_reg)
      C_IDLE: begin
        if (cpu.valid) state_next = C_LOOKUP;
      end
      C_LOOKUP: begin
        // A no-op never touches memory, whatever the line holds.
        if (!is_op || lookup_hit)       state_next = C_RESP;
        else if (line_valid && line_dirty) state_next = C_WB;
        else                            state_next = C_FILL;
      end
      C_WB: begin
        // The line is untouched until FILL, so victim address/data stay stable.
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = {line_tag, idx};
        mem.mem_wdata = line_data;
        if (mem.mem_ack) state_next = C_FILL;
      end
      C_FILL: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = addr_reg;
        if (mem.mem_ack) begin
          we_tag     = 1'b1;
          we_dirty   = 1'b1;
          dirty_in   = 1'b0;
          we_data    = 1'b1;
          data_in    = mem.mem_rdata;
          state_next = C_RESP;
        end
      end
      C_RESP: begin
        cpu.gnt = 1'b1;
        cpu.hit = hit_reg;
        if (is_read) begin
          cpu.rdata    = line_data;
          cpu.rdata_oe = 1'b1;
        end
        // Store merges into the (possibly just filled) line on the gnt edge.
        if (is_write) begin
          we_data  = 1'b1;
          we_dirty = 1'b1;
          dirty_in = 1'b1;
        end
        state_next = C_IDLE;
      end
      default: state_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= C_IDLE;
      rw_reg    <= RW_IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      hit_reg   <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == C_IDLE && cpu.valid) begin
        rw_reg    <= cpu.rw;
        addr_reg  <= cpu.address_cache;
        wdata_reg <= cpu.wdata;
      end
      if (state_reg == C_LOOKUP) hit_reg <= is_op && lookup_hit;
      if (state_reg == C_RESP && is_op) begin
        if (hit_reg) hit_cnt  <= sat_inc(hit_cnt);
        else         miss_cnt <= sat_inc(miss_cnt);
      end
    end
  end

endmodule

// File: tb/tb_cache_responder.sv
// Self-checking bench for cache_responder: expected responses and memory
// transactions are queued when a request is issued and compared when the
// DUT produces them.
module tb_cache_responder;
  import cache_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_responder_if #(.ADDR_W(12), .DATA_W(8)) cpu ();
  cache_mem_if       #(.ADDR_W(12), .DATA_W(8)) mem ();
  logic [15:0] hit_cnt, miss_cnt;

  cache_responder #(
    .ADDR_W  (12),
    .DATA_W  (8),
    .INDEX_W (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu      (cpu.slave),
    .mem      (mem.master),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  typedef struct {
    logic       hit;
    logic       is_read;
    logic [7:0] rdata;
  } resp_t;

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
  } mem_t;

  resp_t resp_q[$];
  mem_t  mem_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_resp(input logic hit, input logic is_read, input logic [7:0] rdata);
    resp_t r;
    r.hit = hit; r.is_read = is_read; r.rdata = rdata;
    resp_q.push_back(r);
  endtask

  task automatic exp_mem(input logic we, input logic [11:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdata, input logic ack);
    mem_t m;
    m.we = we; m.addr = addr; m.wdata = wdata; m.rdata = rdata; m.ack = ack;
    mem_q.push_back(m);
  endtask

  // Called at a falling edge; returns at the falling edge where gnt is seen,
  // leaving valid high so the caller may chain a back-to-back request.
  task automatic issue(input logic [1:0] rw, input logic [11:0] addr, input logic [7:0] wd,
                       input int exp_lat);
    int cyc;
    cyc = 0;
    cpu.valid = 1'b1;
    cpu.rw = rw;
    cpu.address_cache = addr;
    cpu.wdata = wd;
    $display("req  rw=%b addr=%03h wdata=%02h", rw, addr, wd);
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu.gnt && cyc < 200);
    check("gnt_seen", {31'd0, cpu.gnt}, 32'd1);
    if (exp_lat > 0) check("latency", cyc, exp_lat);
  endtask

  task automatic idle();
    cpu.valid = 1'b0;
    cpu.rw = 2'b00;
    @(negedge clk);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rst) begin
      if (cpu.gnt) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          $display("resp hit=%0b oe=%0b rdata=%02h", cpu.hit, cpu.rdata_oe, cpu.rdata);
          check("resp_hit", {31'd0, cpu.hit}, {31'd0, r.hit});
          check("resp_oe", {31'd0, cpu.rdata_oe}, {31'd0, r.is_read});
          check("resp_rdata", {24'd0, cpu.rdata}, r.is_read ? {24'd0, r.rdata} : 32'd0);
        end
      end else begin
        check("no_gnt_quiet", {23'd0, cpu.hit, cpu.rdata_oe, cpu.rdata}, 32'd0);
      end
    end
  end

  // Backing-memory model
  initial begin
    mem_t e;
    mem.mem_ack = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && mem.mem_req) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected", 32'd1, 32'd0);
          for (int i = 0; i < 50 && mem.mem_req; i++) @(negedge clk);
        end else begin
          e = mem_q.pop_front();
          $display("mem  we=%0b addr=%03h wdata=%02h", mem.mem_we, mem.mem_addr, mem.mem_wdata);
          check("mem_we", {31'd0, mem.mem_we}, {31'd0, e.we});
          check("mem_addr", {20'd0, mem.mem_addr}, {20'd0, e.addr});
          if (e.we) check("mem_wdata", {24'd0, mem.mem_wdata}, {24'd0, e.wdata});
          if (e.ack) begin
            @(negedge clk);
            check("mem_addr_hold", {20'd0, mem.mem_addr}, {20'd0, e.addr});
            mem.mem_ack = 1'b1;
            mem.mem_rdata = e.rdata;
            @(negedge clk);
            mem.mem_ack = 1'b0;
            mem.mem_rdata = '0;
          end else begin
            for (int i = 0; i < 50 && mem.mem_req; i++) @(negedge clk);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    cpu.valid = 1'b0;
    cpu.rw = 2'b00;
    cpu.address_cache = '0;
    cpu.wdata = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gnt", {31'd0, cpu.gnt}, 32'd0);
    check("rst_busy", {31'd0, cpu.busy}, 32'd0);
    check("rst_mem_req", {31'd0, mem.mem_req}, 32'd0);
    check("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    check("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: cold read miss
    exp_mem(1'b0, 12'h123, 8'h00, 8'hA5, 1'b1);
    exp_resp(1'b0, 1'b1, 8'hA5);
    issue(RW_READ, 12'h123, 8'h00, 0);
    idle();
    check("t1_miss_cnt", {16'd0, miss_cnt}, 32'd1);
    check("t1_hit_cnt", {16'd0, hit_cnt}, 32'd0);

    // 2: read hit, gnt in the third cycle
    exp_resp(1'b1, 1'b1, 8'hA5);
    issue(RW_READ, 12'h123, 8'h00, 2);
    idle();
    check("t2_hit_cnt", {16'd0, hit_cnt}, 32'd1);

    // 3: write hit makes line dirty, then conflicting read -> WB + FILL (back-to-back)
    exp_resp(1'b1, 1'b0, 8'h00);
    issue(RW_WRITE, 12'h123, 8'h3C, 2);
    exp_mem(1'b1, 12'h123, 8'h3C, 8'h00, 1'b1);
    exp_mem(1'b0, 12'h223, 8'h00, 8'h5A, 1'b1);
    exp_resp(1'b0, 1'b1, 8'h5A);
    issue(RW_READ, 12'h223, 8'h00, 0);
    idle();
    check("t3_hit_cnt", {16'd0, hit_cnt}, 32'd2);
    check("t3_miss_cnt", {16'd0, miss_cnt}, 32'd2);

    // Same-index read right after a write sees the new data
    exp_resp(1'b1, 1'b0, 8'h00);
    issue(RW_WRITE, 12'h223, 8'h99, 2);
    exp_resp(1'b1, 1'b1, 8'h99);
    issue(RW_READ, 12'h223, 8'h00, 3);
    idle();

    // 4: write miss on clean line -> FILL then merge
    exp_mem(1'b0, 12'h456, 8'h00, 8'h11, 1'b1);
    exp_resp(1'b0, 1'b0, 8'h00);
    issue(RW_WRITE, 12'h456, 8'h77, 0);
    idle();
    exp_resp(1'b1, 1'b1, 8'h77);
    issue(RW_READ, 12'h456, 8'h00, 2);
    idle();
    check("t4_hit_cnt", {16'd0, hit_cnt}, 32'd5);
    check("t4_miss_cnt", {16'd0, miss_cnt}, 32'd3);

    // 5: no-op requests on a valid line
    exp_resp(1'b0, 1'b0, 8'h00);
    issue(2'b11, 12'h456, 8'h00, 2);
    idle();
    exp_resp(1'b0, 1'b0, 8'h00);
    issue(2'b00, 12'h456, 8'h00, 2);
    idle();
    check("t5_hit_cnt", {16'd0, hit_cnt}, 32'd5);
    check("t5_miss_cnt", {16'd0, miss_cnt}, 32'd3);

    // 6: reset while FILL is outstanding (line 0x223 is dirty and gets lost)
    exp_mem(1'b0, 12'h345, 8'h00, 8'hEE, 1'b0);
    cpu.valid = 1'b1;
    cpu.rw = RW_READ;
    cpu.address_cache = 12'h345;
    $display("req  rw=%b addr=%03h (to be aborted)", cpu.rw, cpu.address_cache);
    w = 0;
    while (!mem.mem_req && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("t6_fill_reached", {31'd0, mem.mem_req}, 32'd1);
    cpu.valid = 1'b0;
    cpu.rw = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_req_drop", {31'd0, mem.mem_req}, 32'd0);
    check("t6_busy", {31'd0, cpu.busy}, 32'd0);
    check("t6_gnt", {31'd0, cpu.gnt}, 32'd0);
    @(negedge clk);
    check("t6_gnt_hold", {31'd0, cpu.gnt}, 32'd0);
    check("t6_hit_cnt", {16'd0, hit_cnt}, 32'd0);
    check("t6_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    exp_mem(1'b0, 12'h123, 8'h00, 8'hC3, 1'b1);
    exp_resp(1'b0, 1'b1, 8'hC3);
    issue(RW_READ, 12'h123, 8'h00, 0);
    idle();
    exp_mem(1'b0, 12'h223, 8'h00, 8'hD4, 1'b1);
    exp_resp(1'b0, 1'b1, 8'hD4);
    issue(RW_READ, 12'h223, 8'h00, 0);
    idle();
    check("t6_post_miss_cnt", {16'd0, miss_cnt}, 32'd2);
    check("t6_post_hit_cnt", {16'd0, hit_cnt}, 32'd0);

    repeat (3) @(negedge clk);
    check("resp_q_empty", resp_q.size(), 32'd0);
    check("mem_q_empty", mem_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
